// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write arbiter and its read sequencer.
// The latency counter only ever holds RD_LAT-1, which is 0 or 1.
package fifo_arb_pkg;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_HOLD} rd_state_t;

    localparam int LAT_W = 1;

endpackage

// File: rtl/fifo_rd_sequencer.sv
// Read side of the shared FIFO: pops one word at a time, waits out the RAM latency
// and holds the word on a valid/ready output until the consumer takes it.
module fifo_rd_sequencer
    import fifo_arb_pkg::*;
#(
    parameter int width  = 4,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [width-1:0] fifo_dout,
    input  logic             out_ready,
    output logic             fifo_rd,
    output logic             out_valid,
    output logic [width-1:0] out_data
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

    rd_state_t        state;
    logic [LAT_W-1:0] lat_cnt;

    // The pop pulse must see empty in the same cycle, so it cannot be registered.
    always_comb begin
        fifo_rd = 1'b0;
        if (reset && !fifo_empty) begin
            case (state)
                R_IDLE:  fifo_rd = 1'b1;
                R_HOLD:  fifo_rd = out_ready;
                default: fifo_rd = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= R_IDLE;
            lat_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                R_IDLE: begin
                    if (!fifo_empty) begin
                        lat_cnt <= LAT_INIT;
                        state   <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (lat_cnt == '0) begin
                        out_data  <= fifo_dout;
                        out_valid <= 1'b1;
                        state     <= R_HOLD;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                R_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!fifo_empty) begin
                            lat_cnt <= LAT_INIT;
                            state   <= R_WAIT;
                        end else begin
                            state <= R_IDLE;
                        end
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fifo_arbiter.sv
// Shares one FIFO between two writers (round-robin, gated by full) and
// feeds its read side to a single valid/ready consumer.
module fifo_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int width  = 4,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [width-1:0] data0,
    input  logic [width-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             fifo_wr,
    output logic [width-1:0] fifo_din,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    input  logic [width-1:0] fifo_dout,
    output logic             out_valid,
    output logic [width-1:0] out_data,
    input  logic             out_ready
);

    logic rr_last;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset && !fifo_full) begin
            if (req0 && req1) begin
                gnt0 = rr_last;
                gnt1 = !rr_last;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign fifo_wr  = gnt0 | gnt1;
    assign fifo_din = gnt0 ? data0 : (gnt1 ? data1 : '0);

    always_ff @(posedge clk) begin
        if (!reset)
            rr_last <= 1'b1;
        else if (gnt0)
            rr_last <= 1'b0;
        else if (gnt1)
            rr_last <= 1'b1;
    end

    fifo_rd_sequencer #(
        .width (width),
        .RD_LAT(RD_LAT)
    ) u_rd_seq (
        .clk       (clk),
        .reset     (reset),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .out_ready (out_ready),
        .fifo_rd   (fifo_rd),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_fifo_arbiter.sv
// Randomized bench for fifo_arbiter: a queue-based FIFO model stands in for the RAM
// and a one-slot consumer model predicts grants, pops and the output stream.
module tb_fifo_arbiter;

    localparam int W      = 4;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0, req1, gnt0, gnt1;
    logic [W-1:0] data0, data1;
    logic         fifo_wr, fifo_rd, fifo_full, fifo_empty;
    logic [W-1:0] fifo_din, fifo_dout;
    logic         out_valid, out_ready;
    logic [W-1:0] out_data;

    always #5 clk = ~clk;

    fifo_arbiter #(.width(W), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty),
        .fifo_rd   (fifo_rd),
        .fifo_dout (fifo_dout),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // reference model state
    logic [W-1:0] fq[$];
    bit           rr        = 1'b1;
    int           pop_cyc   = -1;
    logic [W-1:0] pop_word  = '0;
    bit           holding   = 1'b0;
    logic [W-1:0] hold_data = '0;
    bit           rst_prev  = 1'b0;
    bit           eg0, eg1, erd, acc, rst_s;
    logic [W-1:0] d0_s, d1_s;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model after the rising edge.
    task automatic step();
        logic [W-1:0] exp_din;
        @(negedge clk);
        eg0 = reset && !fifo_full && req0 && (!req1 || rr);
        eg1 = reset && !fifo_full && req1 && (!req0 || !rr);
        erd = reset && !fifo_empty && (holding ? out_ready : (pop_cyc < 0));
        exp_din = eg0 ? data0 : (eg1 ? data1 : '0);
        check_eq("gnt0", gnt0, eg0);
        check_eq("gnt1", gnt1, eg1);
        check_eq("fifo_wr", fifo_wr, eg0 | eg1);
        check_eq("fifo_din", fifo_din, exp_din);
        check_eq("fifo_rd", fifo_rd, erd);
        check_eq("out_valid", out_valid, holding);
        if (holding)
            check_eq("out_data", out_data, hold_data);
        else if (!reset && !rst_prev)
            check_eq("out_data_rst", out_data, 0);
        acc   = holding && out_ready;
        rst_s = reset;
        d0_s  = data0;
        d1_s  = data1;

        @(posedge clk);
        #1;
        if (!rst_s) begin
            fq.delete();
            rr        = 1'b1;
            holding   = 1'b0;
            pop_cyc   = -1;
            hold_data = '0;
        end else begin
            if (acc) holding = 1'b0;
            if (erd && fq.size() > 0) begin
                pop_word = fq.pop_front();
                pop_cyc  = cyc;
            end
            if (eg0) begin
                fq.push_back(d0_s);
                rr = 1'b0;
            end else if (eg1) begin
                fq.push_back(d1_s);
                rr = 1'b1;
            end
        end
        rst_prev = rst_s;
        cyc++;
        if (pop_cyc >= 0 && cyc == pop_cyc + RD_LAT + 1) begin
            holding   = 1'b1;
            hold_data = pop_word;
            pop_cyc   = -1;
        end
        // the RAM word is only valid in its latency slot; anything else is junk
        fifo_dout  = (pop_cyc >= 0 && cyc == pop_cyc + RD_LAT) ? pop_word : W'($urandom);
        fifo_full  = (fq.size() == DEPTH);
        fifo_empty = (fq.size() == 0);
    endtask

    // Requesters hold until granted, then maybe raise a fresh request with new data.
    task automatic next_reqs(input int p);
        if (!req0 || eg0) begin
            req0  = ($urandom_range(99) < p);
            data0 = W'($urandom);
        end
        if (!req1 || eg1) begin
            req1  = ($urandom_range(99) < p);
            data1 = W'($urandom);
        end
    endtask

    initial begin
        bit found;
        int rdy_pct;
        reset      = 1'b0;
        req0       = 1'b1;
        req1       = 1'b1;
        data0      = 4'h3;
        data1      = 4'h5;
        out_ready  = 1'b0;
        fifo_full  = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        repeat (2) @(posedge clk);
        #1;

        // reset held with both requests up: no grants, outputs cleared
        repeat (3) step();

        // single write of A into an empty FIFO, then watch it come out
        reset = 1'b1;
        req1  = 1'b0;
        data0 = 4'hA;
        step();
        req0 = 1'b0;
        repeat (5) step();

        // tie held for 6 cycles while the consumer streams
        out_ready = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 4'h1;
        data1 = 4'h2;
        repeat (6) step();
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (12) step();

        // fill to full with the consumer stalled, then free single slots
        out_ready = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        repeat (45) begin
            step();
            next_reqs(100);
        end
        repeat (3) begin
            out_ready = 1'b1;
            step();
            next_reqs(100);
            out_ready = 1'b0;
            repeat (3) begin
                step();
                next_reqs(100);
            end
        end

        // consumer stalled for a long stretch while holding a word
        repeat (12) begin
            step();
            next_reqs(100);
        end

        // random traffic with varying back-pressure
        for (int blk = 0; blk < 6; blk++) begin
            rdy_pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 60 : 95);
            repeat (100) begin
                out_ready = ($urandom_range(99) < rdy_pct);
                step();
                next_reqs(40 + 10 * blk);
            end
        end

        // drain
        req0 = 1'b0;
        req1 = 1'b0;
        out_ready = 1'b1;
        repeat (80) step();

        // reset while a read is in flight
        req0  = 1'b1;
        data0 = 4'h7;
        step();
        req0  = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (pop_cyc >= 0) found = 1'b1;
            else step();
        end
        check_eq("wait_reached", found, 1);
        reset = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        repeat (3) step();
        reset = 1'b1;
        repeat (200) begin
            out_ready = ($urandom_range(99) < 70);
            step();
            next_reqs(50);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fifo_arbiter.md
# fifo_arbiter

Controller that shares the 32x4 FIFO between two write requesters and sequences its read side toward one consumer. Round-robin arbitration on the write port, gated by `full`. A 3-state read FSM that issues single-cycle read pulses, absorbs the RAM read latency and presents each word on a valid/ready output. It sits between the requesters/consumer and the FIFO's `read`/`write`/`inputBus`/`outputBus`/`empty`/`full` pins.

## Interface
- `width`, 4, data word width; must match the FIFO width.
- `RD_LAT`, 1, cycles from a `fifo_rd` pulse to valid `fifo_dout`; legal values are 1 or 2.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-low; 0 at a rising edge resets all state.
- `req0`, `req1`  input  1 each  write requests; each is held high until the matching grant.
- `data0`, `data1`  input  width each  write data; each is held stable while its `req` is high.
- `gnt0`, `gnt1`  output  1 each  combinational one-cycle grant; the word is written this cycle.
- `fifo_wr`  output  1  to FIFO `write`; equals `gnt0 | gnt1`.
- `fifo_din`  output  width  to FIFO `inputBus`; the granted requester's data, 0 when idle.
- `fifo_full`, `fifo_empty`  input  1 each  from FIFO `full`/`empty`.
- `fifo_rd`  output  1  to FIFO `read`; one-cycle pop pulse.
- `fifo_dout`  input  width  from FIFO `outputBus`.
- `out_valid`  output  1  registered; `out_data` holds a word.
- `out_data`  output  width  registered word to the consumer.
- `out_ready`  input  1  consumer accepts when high together with `out_valid`.

## Operation
- Write arbitration:
  - `rr_last` is a 1-bit register naming the last-granted requester.
  - If `fifo_full` = 1, no grant is issued.
  - Otherwise a single request wins outright.
  - With both requests high, the requester other than `rr_last` wins.
  - `rr_last` updates only on a grant.
- At most one grant per cycle. `gnt0` and `gnt1` are never high together.
- `full` and `empty` are sampled combinationally in the same cycle, so a write never issues against a full FIFO.
- Read FSM states, with `R_IDLE` on reset:
  - `R_IDLE`: if `fifo_empty` = 0, assert `fifo_rd` this cycle, load the latency counter with `RD_LAT`-1 and go to `R_WAIT`. Otherwise stay.
  - `R_WAIT`: no `fifo_rd`. When the counter is 0, capture `fifo_dout` into `out_data`, set `out_valid` and go to `R_HOLD`. Otherwise decrement.
  - `R_HOLD`: `out_valid` = 1 and `out_data` is held.
    - On `out_ready` = 1 with `fifo_empty` = 0: assert `fifo_rd`, clear `out_valid` next cycle and go to `R_WAIT`.
    - On `out_ready` = 1 with `fifo_empty` = 1: clear `out_valid` and go to `R_IDLE`.
    - On `out_ready` = 0: stay.
- A write and `fifo_rd` in the same cycle are legal and are passed straight to the FIFO.
- Reset values:
  - `rr_last` = 1, so `req0` wins the first tie.
  - State = `R_IDLE`, counter = 0.
  - `out_valid` = 0, `out_data` = 0.
  - `fifo_rd` = 0. Grants follow the inputs combinationally, but are forced to 0 while `reset` = 0.
- Reset asserted mid-operation abandons any in-flight read. The popped word is lost; the FIFO is reset by the same signal.

## Timing
- Write: a word is accepted in the cycle `gnt` is high. Requester-to-FIFO latency is 0 cycles.
- Read: the first word appears on `out_valid` `RD_LAT`+1 cycles after `fifo_empty` falls while in `R_IDLE`.
- Streaming throughput with `out_ready` held at 1 is one word per `RD_LAT`+1 cycles.
- `out_valid` and `out_data` change only on clock edges. `out_data` is stable from the rise of `out_valid` through the accepting cycle.
- `fifo_rd` is never issued while `fifo_empty` = 1, and never in `R_WAIT`.

## Structure
- Package `fifo_arb_pkg` holds:
  - `typedef enum logic [1:0] {R_IDLE, R_WAIT, R_HOLD} rd_state_t`
  - `localparam int LAT_W = 1` (counter width)
- Sub-module `fifo_rd_sequencer` contains the read FSM, latency counter and output register.
- Arbitration stays in `fifo_arbiter`.
- The top-level test wrapper instantiates `fifo_arbiter` together with the existing FIFO.

## Test plan
- Reset then `req0` = 1, `data0` = 4'hA, FIFO empty: `gnt0` and `fifo_wr` are high the same cycle with `fifo_din` = A. `out_valid` rises `RD_LAT`+1 cycles after `empty` falls, with `out_data` = A.
- `req0` and `req1` held high with data 1 and 2 for 6 cycles: grant order is 0,1,0,1,0,1. `rr_last` ends at 1.
- Fill to 32 entries with `out_ready` = 0: at `fifo_full` = 1 both grants are 0 and requests stall. One accepted output frees a slot, and the next grant fires in the cycle `full` falls.
- Burst 5,6,7 with `out_ready` held at 1: `out_data` sequence is 5,6,7, one word per `RD_LAT`+1 cycles. `fifo_rd` is never high while empty.
- `out_ready` = 0 for 10 cycles in `R_HOLD`: `out_data` and `out_valid` are unchanged and no further `fifo_rd` is issued.
- `reset` = 0 during `R_WAIT`: next cycle `out_valid` = 0, state = `R_IDLE`, `rr_last` = 1, and all grants are 0 for the whole reset period.
